spi_master_apb: RTL and testbench

- APB-attached SPI master with separate TX and RX word FIFOs, a programmable word length of 1-32 bits, and programmable SPI mode and clock divider.
- One software-controlled chip select, an interrupt output, and DMA request/acknowledge handshakes.
- Sits on the peripheral APB bus and drives an external SPI slave.

---
 rtl/spi_master_pkg.sv | 51 +++++
 rtl/spi_fifo.sv | 61 ++++++
 rtl/spi_master_apb.sv | 247 ++++++++++++++++++++++++
 tb/tb_spi_master_apb.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared definitions for the APB SPI master.
//   - register offsets (paddr[7:0])
//   - SR / CR / CR1 bit positions and writable masks
//   - transfer engine state enum
//   - byte-strobe to bit-mask helper
package spi_master_pkg;

    localparam logic [7:0] OFF_DATA      = 8'h00;
    localparam logic [7:0] OFF_SR        = 8'h04;
    localparam logic [7:0] OFF_CR        = 8'h08;
    localparam logic [7:0] OFF_CS        = 8'h0C;
    localparam logic [7:0] OFF_FIFO_CTRL = 8'h10;
    localparam logic [7:0] OFF_FIFO_STAT = 8'h14;
    localparam logic [7:0] OFF_CR1       = 8'h18;

    localparam int SR_BUSY     = 0;
    localparam int SR_TX_EMPTY = 1;
    localparam int SR_TX_FULL  = 2;
    localparam int SR_RX_NE    = 3;
    localparam int SR_RX_FULL  = 4;
    localparam int SR_DONE     = 5;
    localparam int SR_RX_OVR   = 6;

    localparam int CR_EN         = 0;
    localparam int CR_CPOL       = 1;
    localparam int CR_CPHA       = 2;
    localparam int CR_IE_TXE     = 8;
    localparam int CR_IE_RXNE    = 9;
    localparam int CR_IE_DONE    = 10;
    localparam int CR_DMA_TX_EN  = 11;
    localparam int CR_DMA_RX_EN  = 12;
    localparam int CR_CLKDIV_LSB = 16;

    // Only these CR bits hold state; the rest read back as 0.
    localparam logic [31:0] CR_MASK = 32'hFFFF_1F07;

    localparam int          CR1_LSB_FIRST = 6;
    localparam logic [6:0]  CR1_RESET     = 7'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } spi_state_e;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/spi_fifo.sv
// spi_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst      : clock, async active-high reset
//   push/din      : write (ignored when full unless popping in the same cycle)
//   pop/dout      : read; dout always shows the head entry
//   flush         : empties the FIFO in one cycle, wins over push
//   full, empty, level
module spi_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wp_q, wp_d, rp_q, rp_d;
    logic             do_push, do_pop;

    assign level = wp_q - rp_q;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
    assign dout  = mem_q[rp_q[AW-1:0]];

    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop) & ~flush;
        wp_d    = wp_q;
        rp_d    = rp_q;
        if (flush) begin
            wp_d = '0;
            rp_d = '0;
        end else begin
            if (do_push) wp_d = wp_q + 1'b1;
            if (do_pop)  rp_d = rp_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/spi_master_apb.sv
// spi_master_apb: APB slave SPI master with TX/RX word FIFOs.
//   APB   : pclk, presetn (active-high async reset), paddr, psel, penable,
//           pwrite, pwdata, pstrb, pprot (ignored), pready, prdata, pslverr
//   SPI   : spi_sclk, spi_mosi, spi_miso, spi_cs_n
//   Misc  : intr (registered level), dma_tx_req/ack, dma_rx_req/ack
//
// state  | meaning
// IDLE   | waiting for EN and TX data; SCLK parked at CPOL, MOSI low
// LOAD   | pop TX word into shifter, present first bit when CPHA=0
// SHIFT  | toggle SCLK every CLKDIV+1 cycles for 2*WL edges
// DONE   | push received word, flag DONE/RX_OVR, chain to next word
module spi_master_apb
    import spi_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [3:0]            pstrb,
    input  logic [2:0]            pprot,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr,
    output logic                  spi_sclk,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic                  spi_cs_n,
    output logic                  intr,
    output logic                  dma_tx_req,
    output logic                  dma_rx_req,
    input  logic                  dma_tx_ack,
    input  logic                  dma_rx_ack
);
    localparam int DW = DATA_WIDTH;
    localparam int IW = $clog2(DW);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic unused_ok;
    assign unused_ok = ^{pprot, paddr[ADDR_WIDTH-1:8]};

    logic [7:0]    off;
    logic          access, wr_en, rd_en, mapped;
    logic [31:0]   cr_q, cr_d;
    logic          cs_q, cs_d;
    logic [6:0]    cr1_q, cr1_d;
    logic          done_q, done_d, rx_ovr_q, rx_ovr_d, intr_q, intr_d;
    logic          tx_ack_q, rx_ack_q;
    logic [DW-1:0] rdata;

    logic          tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic          rx_push, rx_pop, rx_flush, rx_full, rx_empty;
    logic [DW-1:0] tx_dout, rx_dout, rx_word;
    logic [LW-1:0] tx_level, rx_level;

    spi_state_e    state_q;
    logic          sclk_q, mosi_q;
    logic [DW-1:0] sh_q, rx_q;
    logic [15:0]   div_q;
    logic [IW:0]   edge_q;

    logic          en, cpol, cpha, lsb, busy, sample_edge;
    logic [15:0]   clkdiv;
    logic [IW-1:0] wl_m1;

    assign off    = paddr[7:0];
    assign access = psel & penable;
    assign wr_en  = access & pwrite;
    assign rd_en  = access & ~pwrite;
    assign mapped = (off == OFF_DATA) || (off == OFF_SR) || (off == OFF_CR) ||
                    (off == OFF_CS) || (off == OFF_FIFO_CTRL) ||
                    (off == OFF_FIFO_STAT) || (off == OFF_CR1);

    assign en     = cr_q[CR_EN];
    assign cpol   = cr_q[CR_CPOL];
    assign cpha   = cr_q[CR_CPHA];
    assign clkdiv = cr_q[31:CR_CLKDIV_LSB];
    assign lsb    = cr1_q[CR1_LSB_FIRST];
    assign busy   = (state_q != ST_IDLE);
    // Field values of 0 or anything >= DW select the full word width.
    assign wl_m1  = (cr1_q[5:0] == 6'd0 || cr1_q[5:0] >= 6'(DW)) ?
                    IW'(DW - 1) : IW'(cr1_q[5:0] - 6'd1);
    // Sampling happens on the leading edge (SCLK leaving CPOL) unless CPHA.
    assign sample_edge = (sclk_q == cpol) ^ cpha;
    // LSB-first words accumulate from the top; right-align them on push.
    assign rx_word = lsb ? (rx_q >> (~wl_m1)) : rx_q;

    assign tx_push  = wr_en & (off == OFF_DATA) & ~tx_full;
    assign tx_pop   = (state_q == ST_LOAD);
    assign tx_flush = wr_en & (off == OFF_FIFO_CTRL) & pwdata[0];
    assign rx_push  = (state_q == ST_DONE) & ~rx_full;
    assign rx_pop   = rd_en & (off == OFF_DATA);
    assign rx_flush = wr_en & (off == OFF_FIFO_CTRL) & pwdata[1];

    spi_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(pclk), .rst(presetn), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
        .din(pwdata), .dout(tx_dout), .full(tx_full), .empty(tx_empty), .level(tx_level)
    );

    spi_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(pclk), .rst(presetn), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
        .din(rx_word), .dout(rx_dout), .full(rx_full), .empty(rx_empty), .level(rx_level)
    );

    assign pready     = 1'b1;
    assign pslverr    = access & (~mapped | (pwrite & (off == OFF_DATA) & tx_full));
    assign prdata     = rd_en ? rdata : '0;
    assign spi_sclk   = sclk_q;
    assign spi_mosi   = mosi_q;
    assign spi_cs_n   = ~cs_q;
    assign intr       = intr_q;
    assign dma_tx_req = cr_q[CR_DMA_TX_EN] & ~tx_full & ~tx_ack_q;
    assign dma_rx_req = cr_q[CR_DMA_RX_EN] & ~rx_empty & ~rx_ack_q;

    always_comb begin
        rdata = '0;
        case (off)
            OFF_DATA:      rdata = rx_empty ? '0 : rx_dout;
            OFF_SR: begin
                rdata[SR_BUSY]     = busy;
                rdata[SR_TX_EMPTY] = tx_empty;
                rdata[SR_TX_FULL]  = tx_full;
                rdata[SR_RX_NE]    = ~rx_empty;
                rdata[SR_RX_FULL]  = rx_full;
                rdata[SR_DONE]     = done_q;
                rdata[SR_RX_OVR]   = rx_ovr_q;
            end
            OFF_CR:        rdata = cr_q;
            OFF_CS:        rdata[0] = cs_q;
            OFF_FIFO_STAT: rdata[15:0] = {8'(rx_level), 8'(tx_level)};
            OFF_CR1:       rdata[6:0] = cr1_q;
            default:       rdata = '0;
        endcase
    end

    always_comb begin
        cr_d     = cr_q;
        cs_d     = cs_q;
        cr1_d    = cr1_q;
        done_d   = done_q;
        rx_ovr_d = rx_ovr_q;
        if (wr_en) begin
            if (off == OFF_CR)
                cr_d = (cr_q & ~strb_mask(pstrb)) | (pwdata & strb_mask(pstrb) & CR_MASK);
            if (off == OFF_CS && pstrb[0])  cs_d  = pwdata[0];
            if (off == OFF_CR1 && pstrb[0]) cr1_d = pwdata[6:0];
            if (off == OFF_SR && pstrb[0]) begin
                if (pwdata[SR_DONE])   done_d   = 1'b0;
                if (pwdata[SR_RX_OVR]) rx_ovr_d = 1'b0;
            end
        end
        // Hardware set wins over a same-cycle software clear.
        if (state_q == ST_DONE) begin
            if (tx_empty) done_d   = 1'b1;
            if (rx_full)  rx_ovr_d = 1'b1;
        end
        intr_d = (cr_q[CR_IE_TXE] & tx_empty & ~busy) |
                 (cr_q[CR_IE_RXNE] & ~rx_empty) |
                 (cr_q[CR_IE_DONE] & done_q);
    end

    always_ff @(posedge pclk or posedge presetn) begin
        if (presetn) begin
            cr_q     <= '0;
            cs_q     <= 1'b0;
            cr1_q    <= CR1_RESET;
            done_q   <= 1'b0;
            rx_ovr_q <= 1'b0;
            intr_q   <= 1'b0;
            tx_ack_q <= 1'b0;
            rx_ack_q <= 1'b0;
        end else begin
            cr_q     <= cr_d;
            cs_q     <= cs_d;
            cr1_q    <= cr1_d;
            done_q   <= done_d;
            rx_ovr_q <= rx_ovr_d;
            intr_q   <= intr_d;
            tx_ack_q <= dma_tx_ack;
            rx_ack_q <= dma_rx_ack;
        end
    end

    always_ff @(posedge pclk or posedge presetn) begin
        if (presetn) begin
            state_q <= ST_IDLE;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            sh_q    <= '0;
            rx_q    <= '0;
            div_q   <= '0;
            edge_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sclk_q <= cpol;
                    mosi_q <= 1'b0;
                    if (en && !tx_empty) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    sclk_q <= cpol;
                    div_q  <= clkdiv;
                    edge_q <= {wl_m1, 1'b1};
                    rx_q   <= '0;
                    if (!cpha) begin
                        mosi_q <= lsb ? tx_dout[0] : tx_dout[wl_m1];
                        sh_q   <= lsb ? (tx_dout >> 1) : (tx_dout << 1);
                    end else begin
                        mosi_q <= 1'b0;
                        sh_q   <= tx_dout;
                    end
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (div_q == '0) begin
                        div_q  <= clkdiv;
                        sclk_q <= ~sclk_q;
                        if (sample_edge)
                            rx_q <= lsb ? {spi_miso, rx_q[DW-1:1]} : {rx_q[DW-2:0], spi_miso};
                        else if (edge_q != '0) begin
                            // The final edge never launches: no bits are left.
                            mosi_q <= lsb ? sh_q[0] : sh_q[wl_m1];
                            sh_q   <= lsb ? (sh_q >> 1) : (sh_q << 1);
                        end
                        if (edge_q == '0) state_q <= ST_DONE;
                        else              edge_q  <= edge_q - 1'b1;
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    sclk_q  <= cpol;
                    mosi_q  <= 1'b0;
                    state_q <= (en && !tx_empty) ? ST_LOAD : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_apb.sv
module tb_spi_master_apb;

    logic        pclk = 1'b0;
    logic        presetn = 1'b1;
    logic [31:0] paddr = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = 4'hF;
    logic [2:0]  pprot = '0;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic        spi_sclk, spi_mosi, spi_miso, spi_cs_n, intr;
    logic        dma_tx_req, dma_rx_req;
    logic        dma_tx_ack = 1'b0, dma_rx_ack = 1'b0;

    always #5 pclk = ~pclk;
    assign spi_miso = spi_mosi;

    spi_master_apb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .pready(pready),
        .prdata(prdata), .pslverr(pslverr), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_cs_n(spi_cs_n), .intr(intr), .dma_tx_req(dma_tx_req),
        .dma_rx_req(dma_rx_req), .dma_tx_ack(dma_tx_ack), .dma_rx_ack(dma_rx_ack)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data, output logic err);
        @(posedge pclk); #1;
        paddr = {24'h0, addr}; pwdata = data; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        #1 err = pslverr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [31:0] data, output logic err);
        @(posedge pclk); #1;
        paddr = {24'h0, addr}; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        #1 data = prdata; err = pslverr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        logic e;
        apb_write(addr, data, e);
    endtask

    task automatic rd(input logic [7:0] addr, output logic [31:0] data);
        logic e;
        apb_read(addr, data, e);
    endtask

    // Bounded wait for the engine to drain the TX FIFO and go idle.
    task automatic wait_idle(input string name);
        logic [31:0] sr;
        logic        ok;
        ok = 1'b0;
        repeat (2) @(posedge pclk);
        for (int n = 0; n < 4000 && !ok; n++) begin
            rd(8'h04, sr);
            if (sr[0] == 1'b0 && sr[1] == 1'b1) ok = 1'b1;
        end
        if (!ok) check({name, "/timeout"}, 32'(ok), 32'd1);
    endtask

    // SPI line monitor: records the MOSI bit at every sample edge, edge times
    // and leading-edge count while enabled.
    logic mon_en = 1'b0, mon_cpol = 1'b0, mon_cpha = 1'b0, prev_sclk = 1'b0;
    logic sampled[$];
    int   edge_cyc[$];
    int   cyc = 0, pulses = 0, cs_bad = 0;

    always @(negedge pclk) begin
        cyc++;
        if (mon_en && spi_sclk !== prev_sclk) begin
            edge_cyc.push_back(cyc);
            if ((prev_sclk == mon_cpol) ^ mon_cpha) sampled.push_back(spi_mosi);
            if (spi_sclk != mon_cpol) pulses++;
            if (spi_cs_n) cs_bad++;
        end
        prev_sclk = spi_sclk;
    end

    function automatic logic [31:0] wmask(input int wl);
        return (wl >= 32) ? 32'hFFFF_FFFF : ((32'h1 << wl) - 32'h1);
    endfunction

    // One loopback word: configure, send, and compare line activity and
    // the word read back against what the SPI rules say must happen.
    task automatic run_xfer(input string name, input logic [31:0] cr, input logic [31:0] cr1,
                            input logic [31:0] data, input logic [31:0] exp);
        int          wl, nmis, nbad, hp;
        logic        lsb, eb;
        logic [31:0] rdv;
        logic        e;
        wl  = (cr1[5:0] == 6'd0) ? 32 : int'(cr1[5:0]);
        lsb = cr1[6];
        hp  = int'(cr[31:16]) + 1;
        wr(8'h18, cr1);
        wr(8'h08, cr);
        wr(8'h0C, 32'h1);
        repeat (3) @(posedge pclk);
        #1;
        check({name, "/idle_sclk"}, 32'(spi_sclk), 32'(cr[1]));
        if (cr[10]) check({name, "/intr_pre"}, 32'(intr), 32'd0);
        sampled.delete(); edge_cyc.delete();
        pulses = 0; cs_bad = 0;
        mon_cpol = cr[1]; mon_cpha = cr[2]; mon_en = 1'b1;
        apb_write(8'h00, data, e);
        wait_idle(name);
        mon_en = 1'b0;
        apb_read(8'h00, rdv, e);
        check({name, "/rx"}, rdv, exp);
        check({name, "/pulses"}, 32'(pulses), 32'(wl));
        check({name, "/cs_low"}, 32'(cs_bad), 32'd0);
        check({name, "/nbits"}, 32'(sampled.size()), 32'(wl));
        nmis = 0;
        for (int i = 0; i < wl && i < sampled.size(); i++) begin
            eb = lsb ? data[i] : data[wl-1-i];
            if (sampled[i] !== eb) nmis++;
        end
        check({name, "/mosi_seq"}, 32'(nmis), 32'd0);
        nbad = 0;
        for (int i = 1; i < edge_cyc.size(); i++)
            if (edge_cyc[i] - edge_cyc[i-1] != hp) nbad++;
        check({name, "/half_period"}, 32'(nbad), 32'd0);
        if (cr[10]) check({name, "/intr_done"}, 32'(intr), 32'd1);
        wr(8'h04, 32'h60);
    endtask

    typedef struct {
        logic [31:0] cr;
        logic [31:0] cr1;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] rdv, cr, cr1, data;
        logic        e;
        logic [31:0] words[4];
        int          wl, cdiv;

        vecs[0] = '{32'h0000_0401, 32'h20, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_0001, 32'h48, 32'h0000_01A5, 32'h0000_00A5};
        vecs[2] = '{32'h0003_0007, 32'h20, 32'h1234_5678, 32'h1234_5678};
        vecs[3] = '{32'h0000_0003, 32'h10, 32'hFFFF_A55A, 32'h0000_A55A};
        vecs[4] = '{32'h0001_0005, 32'h45, 32'h0000_0013, 32'h0000_0013};
        vecs[5] = '{32'h0000_0001, 32'h01, 32'h0000_0003, 32'h0000_0001};
        vecs[6] = '{32'h0002_0001, 32'h00, 32'h8000_0001, 32'h8000_0001};

        // Reset values.
        repeat (2) @(posedge pclk);
        #1;
        check("rst/cs_n", 32'(spi_cs_n), 32'd1);
        check("rst/intr", 32'(intr), 32'd0);
        check("rst/sclk", 32'(spi_sclk), 32'd0);
        check("rst/mosi", 32'(spi_mosi), 32'd0);
        check("rst/dma", {30'd0, dma_tx_req, dma_rx_req}, 32'd0);
        check("rst/prdata", prdata, 32'd0);
        check("rst/pslverr", 32'(pslverr), 32'd0);
        presetn = 1'b0;
        rd(8'h08, rdv); check("rst/cr", rdv, 32'h0);
        rd(8'h18, rdv); check("rst/cr1", rdv, 32'h20);
        rd(8'h04, rdv); check("rst/sr", rdv, 32'h2);
        check("rst/pready", 32'(pready), 32'd1);

        // Directed vectors.
        foreach (vecs[i])
            run_xfer($sformatf("vec%0d", i), vecs[i].cr, vecs[i].cr1, vecs[i].data, vecs[i].exp);

        // Random loopback words against the model.
        for (int k = 0; k < 16; k++) begin
            wl   = int'($urandom_range(1, 32));
            cdiv = int'($urandom_range(0, 2));
            cr   = 32'h1 | (32'($urandom_range(0, 1)) << 1) | (32'($urandom_range(0, 1)) << 2)
                   | (32'(cdiv) << 16);
            cr1  = ((wl == 32 && $urandom_range(0, 1) == 1) ? 32'h0 : 32'(wl))
                   | (32'($urandom_range(0, 1)) << 6);
            data = $urandom;
            run_xfer($sformatf("rnd%0d", k), cr, cr1, data, data & wmask(wl));
        end

        // TX full, RX overrun, W1C.
        wr(8'h08, 32'h0);
        wr(8'h18, 32'h20);
        for (int i = 0; i < 5; i++) begin
            data = $urandom;
            if (i < 4) words[i] = data;
            apb_write(8'h00, data, e);
            check($sformatf("fill%0d/pslverr", i), 32'(e), (i < 4) ? 32'd0 : 32'd1);
        end
        rd(8'h14, rdv); check("fill/tx_level", rdv, 32'h4);
        wr(8'h08, 32'h1);
        wait_idle("burst4");
        rd(8'h04, rdv);
        check("burst4/rx_ovr", 32'(rdv[6]), 32'd0);
        check("burst4/rx_full", 32'(rdv[4]), 32'd1);
        check("burst4/done", 32'(rdv[5]), 32'd1);
        rd(8'h14, rdv); check("burst4/levels", rdv, 32'h0400);
        wr(8'h00, 32'h55);
        wait_idle("ovr");
        rd(8'h04, rdv); check("ovr/set", 32'(rdv[6]), 32'd1);
        wr(8'h04, 32'h40);
        rd(8'h04, rdv); check("ovr/w1c", 32'(rdv[6]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd(8'h00, rdv);
            check($sformatf("drain%0d", i), rdv, words[i]);
        end
        rd(8'h00, rdv); check("rx_empty_read", rdv, 32'h0);
        wr(8'h04, 32'h60);

        // Flush and write-only FIFO_CTRL.
        wr(8'h08, 32'h0);
        wr(8'h00, 32'h11);
        wr(8'h00, 32'h22);
        rd(8'h14, rdv); check("flush/pre", rdv, 32'h2);
        wr(8'h10, 32'h1);
        rd(8'h14, rdv); check("flush/post", rdv, 32'h0);
        rd(8'h10, rdv); check("fifo_ctrl/read", rdv, 32'h0);

        // Unmapped offset.
        apb_read(8'h20, rdv, e); check("unmapped/rd_err", 32'(e), 32'd1);
        apb_write(8'h20, 32'h1, e); check("unmapped/wr_err", 32'(e), 32'd1);
        apb_read(8'h08, rdv, e); check("mapped/rd_err", 32'(e), 32'd0);

        // DMA request and ack masking.
        wr(8'h08, 32'h0000_1800);
        @(posedge pclk); #1;
        check("dma/tx_req", 32'(dma_tx_req), 32'd1);
        check("dma/rx_req_empty", 32'(dma_rx_req), 32'd0);
        dma_tx_ack = 1'b1;
        @(posedge pclk); #1;
        dma_tx_ack = 1'b0;
        check("dma/tx_masked", 32'(dma_tx_req), 32'd0);
        @(posedge pclk); #1;
        check("dma/tx_back", 32'(dma_tx_req), 32'd1);

        // Reset in the middle of a slow transfer.
        wr(8'h08, 32'h0014_0001);
        wr(8'h0C, 32'h1);
        wr(8'h00, 32'hFFFF_FFFF);
        repeat (30) @(posedge pclk);
        #1 presetn = 1'b1;
        #1;
        check("abort/sclk", 32'(spi_sclk), 32'd0);
        check("abort/mosi", 32'(spi_mosi), 32'd0);
        check("abort/cs_n", 32'(spi_cs_n), 32'd1);
        @(posedge pclk); #1 presetn = 1'b0;
        rd(8'h04, rdv); check("abort/sr", rdv, 32'h2);
        rd(8'h08, rdv); check("abort/cr", rdv, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
